btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 148 ++++++++++++++
 tb/tb_btn_debounce.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Push-button debouncer with a stability-counting FSM and a
//            saturating count of rejected bounces. BTN_DEBOUNCE_SYNC_EN
//            selects a two-flop synchronizer input stage instead of a single
//            sampling register.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    output logic       sig_out,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_WAIT_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       c_GLITCH_MAX = 8'hFF;

    logic             w_s;
    state_t           r_state_q;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic [7:0]       r_glitch_q;
    logic [7:0]       w_glitch_d;
    logic             w_glitch_inc;
    logic             r_sig_out_q;
    logic             w_sig_out_d;

`ifdef BTN_DEBOUNCE_SYNC_EN
    logic [1:0] r_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q <= 2'b00;
        end else begin
            r_sync_q <= {r_sync_q[0], sig_in};
        end
    end

    assign w_s = r_sync_q[1];
`else
    logic r_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q <= 1'b0;
        end else begin
            r_sync_q <= sig_in;
        end
    end

    assign w_s = r_sync_q;
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_glitch_inc = 1'b0;
        case (r_state_q)
            ST_STABLE_LO: begin
                if (w_s) begin
                    w_state_d = ST_WAIT_HI;
                    w_cnt_d   = c_CNT_ONE;
                end else begin
                    w_cnt_d   = '0;
                end
            end
            ST_WAIT_HI: begin
                // Completion needs s still high on the final cycle.
                if (w_s) begin
                    if (r_cnt_q == c_CNT_LAST) begin
                        w_state_d = ST_STABLE_HI;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d   = r_cnt_q + c_CNT_ONE;
                    end
                end else begin
                    w_state_d    = ST_STABLE_LO;
                    w_cnt_d      = '0;
                    w_glitch_inc = 1'b1;
                end
            end
            ST_STABLE_HI: begin
                if (!w_s) begin
                    w_state_d = ST_WAIT_LO;
                    w_cnt_d   = c_CNT_ONE;
                end else begin
                    w_cnt_d   = '0;
                end
            end
            ST_WAIT_LO: begin
                if (!w_s) begin
                    if (r_cnt_q == c_CNT_LAST) begin
                        w_state_d = ST_STABLE_LO;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d   = r_cnt_q + c_CNT_ONE;
                    end
                end else begin
                    w_state_d    = ST_STABLE_HI;
                    w_cnt_d      = '0;
                    w_glitch_inc = 1'b1;
                end
            end
            default: begin
                w_state_d = ST_STABLE_LO;
                w_cnt_d   = '0;
            end
        endcase

        w_glitch_d  = (w_glitch_inc && (r_glitch_q != c_GLITCH_MAX)) ?
                      r_glitch_q + 8'd1 : r_glitch_q;
        w_sig_out_d = (w_state_d == ST_STABLE_HI) || (w_state_d == ST_WAIT_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_STABLE_LO;
            r_cnt_q     <= '0;
            r_glitch_q  <= 8'd0;
            r_sig_out_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_glitch_q  <= w_glitch_d;
            r_sig_out_q <= w_sig_out_d;
        end
    end

    assign sig_out    = r_sig_out_q;
    assign glitch_cnt = r_glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce
// Brief    : Directed self-checking bench for btn_debounce with STABLE_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce;

    localparam int STABLE = 4;
`ifdef BTN_DEBOUNCE_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int LAT = D + STABLE;

    logic       clk;
    logic       rst;
    logic       sig_in;
    logic       sig_out;
    logic [7:0] glitch_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int rises    = 0;
    logic prev_out = 1'b0;

    btn_debounce #(
        .STABLE_CYCLES(STABLE),
        .CNT_W        (3)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .sig_out   (sig_out),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge; also tracks rising edges.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sig_out && !prev_out) rises++;
        prev_out = sig_out;
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_eq("reset_sig_out", int'(sig_out), 0);
        chk_eq("reset_glitch", int'(glitch_cnt), 0);

        for (int i = 0; i < 20; i++) begin
            tick();
            chk_eq("idle_sig_out", int'(sig_out), 0);
            chk_eq("idle_glitch", int'(glitch_cnt), 0);
        end

        // Rising edge latency and single downstream edge.
        rises  = 0;
        sig_in = 1'b1;
        for (int k = 1; k <= LAT + 10; k++) begin
            tick();
            chk_eq("rise_latency", int'(sig_out), (k >= LAT) ? 1 : 0);
        end
        chk_eq("rise_edge_count", rises, 1);

        // Falling edge latency.
        sig_in = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            chk_eq("fall_latency", int'(sig_out), (k >= LAT) ? 0 : 1);
        end
        chk_eq("fall_glitch", int'(glitch_cnt), 0);

        // Three-cycle bounce rejected.
        sig_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_eq("bounce_sig_out", int'(sig_out), 0);
        end
        sig_in = 1'b0;
        for (int k = 0; k < D + 2; k++) begin
            tick();
            chk_eq("bounce_sig_out", int'(sig_out), 0);
        end
        chk_eq("bounce_glitch_1", int'(glitch_cnt), 1);

        // 299 more bounces: saturation at 255.
        for (int r = 0; r < 299; r++) begin
            sig_in = 1'b1;
            tick(); tick(); tick();
            sig_in = 1'b0;
            tick();
        end
        for (int k = 0; k < D + 2; k++) tick();
        chk_eq("glitch_saturate", int'(glitch_cnt), 255);
        chk_eq("saturate_sig_out", int'(sig_out), 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("rst_clears_glitch", int'(glitch_cnt), 0);

        // Toggle every cycle for 50 cycles: 25 rejected high pulses.
        for (int i = 0; i < 50; i++) begin
            sig_in = (i % 2 == 0);
            tick();
            chk_eq("toggle_sig_out", int'(sig_out), 0);
        end
        sig_in = 1'b0;
        for (int k = 0; k < D + 2; k++) tick();
        chk_eq("toggle_glitch", int'(glitch_cnt), 25);

        // Exactly STABLE-cycle pulse is accepted, then released.
        sig_in = 1'b1;
        for (int k = 1; k <= STABLE + LAT + 2; k++) begin
            tick();
            if (k == STABLE) sig_in = 1'b0;
            chk_eq("exact_pulse",
                   int'(sig_out), ((k >= LAT) && (k < STABLE + LAT)) ? 1 : 0);
        end
        chk_eq("exact_pulse_glitch", int'(glitch_cnt), 25);

        // Reset during WAIT_LO abandons the transition.
        sig_in = 1'b1;
        for (int k = 0; k < LAT + 2; k++) tick();
        chk_eq("pre_rst_high", int'(sig_out), 1);
        sig_in = 1'b0;
        for (int k = 0; k < D + 1; k++) tick();
        chk_eq("in_wait_lo_high", int'(sig_out), 1);
        sig_in = 1'b1;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("mid_wait_rst_out", int'(sig_out), 0);
        chk_eq("mid_wait_rst_glitch", int'(glitch_cnt), 0);
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            chk_eq("post_rst_rise", int'(sig_out), (k >= LAT) ? 1 : 0);
            chk_eq("post_rst_glitch", int'(glitch_cnt), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
